// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchroniser and mid-bit sampling.
// Optional even parity (8E1) is enabled by defining the macro UART_RX_PARITY_EN.
// Good bytes appear on RX_Bytes with a 1-cycle RX_Done; bad frames pulse RX_Error.
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       RX_Serial,
  output logic [7:0] RX_Bytes,
  output logic       RX_Done,
  output logic       RX_Active,
  output logic       RX_Error
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4,
    PARITY  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_t;
`endif

  state_t state, state_nxt;

  // synchroniser stages; rx_s is the only view of the line the FSM uses
  logic rx_p0, rx_p1;
  logic rx_s;

  logic [CW-1:0] clk_cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift,   shift_nxt;
  logic [7:0]    bytes_nxt;
  logic          done_nxt, err_nxt, active_nxt;
  logic          cnt_last;
  logic          stop_ok;

`ifdef UART_RX_PARITY_EN
  logic par_err, par_err_nxt;
`endif

  assign rx_s     = rx_p1;
  assign cnt_last = (clk_cnt == CNT_LAST);

  // A frame is accepted only with a high stop bit (and matching parity when enabled).
`ifdef UART_RX_PARITY_EN
  assign stop_ok = rx_s & ~par_err;
`else
  assign stop_ok = rx_s;
`endif

  // Two-flop synchroniser; reset to the idle (high) line level.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= RX_Serial;
      rx_p1 <= rx_p0;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter, shift and output decode.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_last ? '0 : clk_cnt + 1'b1;
    bit_nxt    = bit_idx;
    shift_nxt  = shift;
    bytes_nxt  = RX_Bytes;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    active_nxt = RX_Active;
`ifdef UART_RX_PARITY_EN
    par_err_nxt = par_err;
`endif

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (!rx_s) begin
          state_nxt  = START;
          active_nxt = 1'b1;
        end
      end

      START: begin
        // Re-check the line half a bit in; a short low pulse is treated as noise.
        if (clk_cnt == CNT_HALF) begin
          cnt_nxt = '0;
          bit_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
          end else begin
            state_nxt  = IDLE;
            active_nxt = 1'b0;
          end
        end
      end

      DATA: begin
        if (cnt_last) begin
          shift_nxt[bit_idx] = rx_s;
          cnt_nxt            = '0;
          if (bit_idx == 3'd7) begin
            bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: data bits XOR parity bit must be zero.
        if (cnt_last) begin
          par_err_nxt = ^{shift, rx_s};
          cnt_nxt     = '0;
          state_nxt   = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt_last) begin
          cnt_nxt = '0;
          if (stop_ok) begin
            bytes_nxt  = shift;
            done_nxt   = 1'b1;
            active_nxt = 1'b0;
            state_nxt  = IDLE;
          end else begin
            err_nxt = 1'b1;
            if (rx_s) begin
              // Stop bit fine, only parity bad: line already idle.
              active_nxt = 1'b0;
              state_nxt  = IDLE;
            end else begin
              state_nxt = RECOVER;
            end
          end
        end
      end

      RECOVER: begin
        // Hold off until the line returns high so a break never looks like a start.
        cnt_nxt = '0;
        if (rx_s) begin
          active_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end

      default: begin
        cnt_nxt    = '0;
        bit_nxt    = '0;
        active_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      RX_Bytes  <= '0;
      RX_Done   <= 1'b0;
      RX_Error  <= 1'b0;
      RX_Active <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      clk_cnt   <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      RX_Bytes  <= bytes_nxt;
      RX_Done   <= done_nxt;
      RX_Error  <= err_nxt;
      RX_Active <= active_nxt;
`ifdef UART_RX_PARITY_EN
      par_err   <= par_err_nxt;
`endif
    end
  end

endmodule
